// File: rtl/wb_arbiter.sv
// Round-robin N:1 Wishbone arbiter. Grant is held for the winner's whole cyc tenure, and a
// per-transfer watchdog turns a stalled transfer into a bus error.
module wb_arbiter #(
    parameter int unsigned N             = 2,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,

    // Upstream masters, packed by index
    input  logic [N*32-1:0] m_addr_i,
    input  logic [N*32-1:0] m_wdata_i,
    input  logic [N*4-1:0]  m_sel_i,
    input  logic [N-1:0]    m_we_i,
    input  logic [N-1:0]    m_cyc_i,
    input  logic [N-1:0]    m_stb_i,
    output logic [N*32-1:0] m_rdata_o,
    output logic [N-1:0]    m_ack_o,
    output logic [N-1:0]    m_err_o,

    // Downstream port to the interconnect
    output logic [31:0]     s_addr_o,
    output logic [31:0]     s_wdata_o,
    output logic [3:0]      s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [31:0]     s_rdata_i,
    input  logic            s_ack_i,
    input  logic            s_err_i
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic        WdEn = (TimeoutCycles > 0);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] last_grant_q, last_grant_d;
    logic [CntW-1:0] wd_cnt_q, wd_cnt_d;

    logic [N-1:0]    req;
    logic            win_found;
    logic [IdxW-1:0] win_idx;
    logic [IdxW:0]   cand;

    logic [31:0]     g_addr, g_wdata;
    logic [3:0]      g_sel;
    logic            g_we, g_cyc, g_stb;
    logic            stalled, timeout;

    assign req = m_cyc_i & m_stb_i;

    // Scan last_grant+1, last_grant+2, ... modulo N; first requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant_q;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = {1'b0, last_grant_q} + (IdxW+1)'(k);
            if (cand >= (IdxW+1)'(N)) begin
                cand = cand - (IdxW+1)'(N);
            end
            if (!win_found && req[cand[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        g_sel   = '0;
        g_we    = 1'b0;
        g_cyc   = 1'b0;
        g_stb   = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant_q == IdxW'(i)) begin
                g_addr  = m_addr_i[i*32 +: 32];
                g_wdata = m_wdata_i[i*32 +: 32];
                g_sel   = m_sel_i[i*4 +: 4];
                g_we    = m_we_i[i];
                g_cyc   = m_cyc_i[i];
                g_stb   = m_stb_i[i];
            end
        end
    end

    // An ack or err arriving in the limit cycle wins over the timeout.
    assign stalled = (state_q == StBusy) && g_stb && !s_ack_i && !s_err_i;
    assign timeout = WdEn && stalled && (wd_cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= IdxW'(N - 1);
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d      = StBusy;
                    grant_d      = win_idx;
                    last_grant_d = win_idx;
                end
            end
            StBusy: begin
                if (!g_cyc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!WdEn || timeout || !stalled) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + CntW'(1);
        end
    end

    always_comb begin
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m_rdata_o = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        if (state_q == StBusy) begin
            s_addr_o  = g_addr;
            s_wdata_o = g_wdata;
            s_sel_o   = g_sel;
            s_we_o    = g_we;
            s_cyc_o   = g_cyc & ~timeout;
            s_stb_o   = g_stb & ~timeout;
            for (int i = 0; i < int'(N); i++) begin
                if (grant_q == IdxW'(i)) begin
                    m_rdata_o[i*32 +: 32] = s_rdata_i;
                    m_ack_o[i]            = s_ack_i;
                    m_err_o[i]            = s_err_i | timeout;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, all checked cycle by cycle
// against a tenure-level reference model.
module tb_wb_arbiter;

    localparam int N = 3;
    localparam int T = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*32-1:0] m_addr, m_wdata, m_rdata;
    logic [N*4-1:0]  m_sel;
    logic [N-1:0]    m_we, m_cyc, m_stb, m_ack, m_err;
    logic [31:0]     s_addr, s_wdata, s_rdata;
    logic [3:0]      s_sel;
    logic            s_we, s_cyc, s_stb, s_ack, s_err;

    always #5 clk = ~clk;

    wb_arbiter #(.N(N), .TimeoutCycles(T)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_sel_i   (m_sel),
        .m_we_i    (m_we),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_rdata_o (m_rdata),
        .m_ack_o   (m_ack),
        .m_err_o   (m_err),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_sel_o   (s_sel),
        .s_we_o    (s_we),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_rdata_i (s_rdata),
        .s_ack_i   (s_ack),
        .s_err_i   (s_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: who owns the bus, where the round-robin pointer sits, and how many
    // consecutive stalled cycles the current transfer has accumulated.
    bit md_busy;
    int md_owner, md_last, md_stall;

    task automatic model_reset();
        md_busy  = 1'b0;
        md_owner = 0;
        md_last  = N - 1;
        md_stall = 0;
    endtask

    function automatic bit model_stalled();
        return md_busy && m_stb[md_owner] && !s_ack && !s_err;
    endfunction

    function automatic bit model_tmo();
        return (T > 0) && model_stalled() && (md_stall + 1 == T);
    endfunction

    task automatic compare_outputs();
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_sel;
        logic [2:0]  e_ctl;
        logic [N-1:0] e_ack, e_err;
        logic [31:0] e_rd [N];
        bit tmo;
        int g;
        e_addr = '0; e_wdata = '0; e_sel = '0; e_ctl = '0; e_ack = '0; e_err = '0;
        for (int i = 0; i < N; i++) e_rd[i] = '0;
        if (md_busy) begin
            g       = md_owner;
            tmo     = model_tmo();
            e_addr  = m_addr[g*32 +: 32];
            e_wdata = m_wdata[g*32 +: 32];
            e_sel   = m_sel[g*4 +: 4];
            e_ctl   = {m_we[g], m_cyc[g] && !tmo, m_stb[g] && !tmo};
            e_ack[g] = s_ack;
            e_err[g] = s_err || tmo;
            e_rd[g]  = s_rdata;
        end
        check("s_addr", s_addr, e_addr);
        check("s_wdata", s_wdata, e_wdata);
        check("s_sel", 32'(s_sel), 32'(e_sel));
        check("s_we_cyc_stb", 32'({s_we, s_cyc, s_stb}), 32'(e_ctl));
        check("m_ack", 32'(m_ack), 32'(e_ack));
        check("m_err", 32'(m_err), 32'(e_err));
        for (int i = 0; i < N; i++) check("m_rdata", m_rdata[i*32 +: 32], e_rd[i]);
    endtask

    task automatic model_update();
        bit found;
        int c;
        if (rst) begin
            model_reset();
            return;
        end
        if (!md_busy) begin
            md_stall = 0;
            found    = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (md_last + k) % N;
                if (!found && m_cyc[c] && m_stb[c]) begin
                    found    = 1'b1;
                    md_busy  = 1'b1;
                    md_owner = c;
                    md_last  = c;
                end
            end
        end else begin
            if (model_stalled() && !model_tmo()) md_stall++;
            else md_stall = 0;
            if (!m_cyc[md_owner]) md_busy = 1'b0;
        end
    endtask

    // Called at the falling edge once inputs are driven; leaves us at the next falling edge.
    task automatic settle();
        #1;
        if (rst) model_reset();
        compare_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m_addr = '0; m_wdata = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        s_rdata = '0; s_ack = 1'b0; s_err = 1'b0;
    endtask

    task automatic set_master(input int i, input bit cyc, input bit stb, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        m_cyc[i] = cyc;
        m_stb[i] = stb;
        m_we[i]  = we;
        m_sel[i*4 +: 4]    = 4'hF;
        m_addr[i*32 +: 32] = addr;
        m_wdata[i*32 +: 32] = wdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (3) begin
            settle();
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        bit [1:0] drop;
        bit prev_stb, prev_ack;
        int starts[$];
        logic [31:0] who[$];
        logic [31:0] lk_addr [10] = '{0, 'hA0, 'hA0, 'hA0, 'hA0, 'hA0, 'hA0, 'hA0, 0, 'hB0};
        logic [31:0] lk_wd   [10] = '{0, 'h11, 'h11, 'h11, 'h11, 'h22, 'h22, 'h22, 0, 0};
        bit lk_cyc [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        bit lk_stb [10] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
        bit lk_ack [10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
        bit to_err [6]  = '{0, 0, 0, 0, 1, 0};
        bit to_cyc [6]  = '{0, 1, 1, 1, 0, 1};
        bit va_ack [5]  = '{0, 0, 0, 0, 1};
        bit va_cyc [5]  = '{0, 1, 1, 1, 1};

        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk);

        // Reset and idle
        do_reset();
        settle();
        check("idle_s_cyc", 32'(s_cyc), 0);
        tick();

        // Single master read, slave acks one cycle after seeing stb
        do_reset();
        set_master(1, 1, 1, 0, 32'h0000_1000, 0);
        settle();
        check("sm_idle_cyc", 32'(s_cyc), 0);
        tick();
        settle();
        check("sm_addr", s_addr, 32'h0000_1000);
        check("sm_no_ack_yet", 32'(m_ack), 0);
        tick();
        s_ack = 1'b1;
        s_rdata = 32'hDEAD_BEEF;
        settle();
        check("sm_ack", 32'(m_ack), 32'b010);
        check("sm_rdata1", m_rdata[63:32], 32'hDEAD_BEEF);
        check("sm_rdata0", m_rdata[31:0], 0);
        tick();
        clear_inputs();
        settle();
        tick();

        // Contention: masters 0 and 1 request continuously, one transfer per tenure
        do_reset();
        drop = '0; prev_stb = 1'b0; prev_ack = 1'b0;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 2; i++) set_master(i, !drop[i], !drop[i], 0, 32'(i), 0);
            s_ack = prev_stb && !prev_ack;
            settle();
            if (s_stb && !prev_stb) begin
                starts.push_back(c);
                who.push_back(s_addr);
            end
            drop = m_ack[1:0];
            prev_stb = s_stb;
            prev_ack = s_ack;
            tick();
        end
        check("cont_tenures", 32'(starts.size()), 4);
        for (int k = 0; k < 4; k++)
            check("cont_order", (k < who.size()) ? who[k] : 32'hFFFF_FFFF, 32'(k % 2));
        // stb, ack, release, one IDLE cycle, next stb: tenures start 4 cycles apart
        for (int k = 0; k < 3; k++)
            check("cont_gap", (k + 1 < starts.size()) ? 32'(starts[k+1] - starts[k]) : 0, 4);
        clear_inputs();
        settle();
        tick();

        // Locked cycle: master 0 holds cyc over two writes while master 1 waits
        do_reset();
        for (int c = 0; c < 10; c++) begin
            set_master(0, lk_cyc[c], lk_stb[c], 1, 32'hA0, lk_wd[c]);
            set_master(1, 1, 1, 0, 32'hB0, 0);
            s_ack = lk_ack[c];
            settle();
            check("lock_addr", s_addr, lk_addr[c]);
            check("lock_wdata", s_wdata, lk_wd[c]);
            check("lock_m1_ack", 32'(m_ack[1]), 0);
            tick();
        end
        clear_inputs();
        settle();
        tick();

        // Watchdog: no ack ever, then ack landing in the limit cycle
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_master(0, 1, 1, 0, 32'hC0, 0);
            settle();
            check("to_err", 32'(m_err[0]), 32'(to_err[c]));
            check("to_cyc", 32'(s_cyc), 32'(to_cyc[c]));
            check("to_stb", 32'(s_stb), 32'(to_cyc[c]));
            tick();
        end
        set_master(0, 0, 0, 0, 32'hC0, 0);
        settle();
        tick();
        for (int c = 0; c < 5; c++) begin
            set_master(0, 1, 1, 0, 32'hC4, 0);
            s_ack = va_ack[c];
            settle();
            check("tov_ack", 32'(m_ack[0]), 32'(va_ack[c]));
            check("tov_err", 32'(m_err[0]), 0);
            check("tov_cyc", 32'(s_cyc), 32'(va_cyc[c]));
            tick();
        end
        clear_inputs();
        settle();
        tick();

        // Reset in the middle of a transfer
        do_reset();
        set_master(0, 1, 1, 0, 32'hA0, 0);
        set_master(1, 1, 1, 0, 32'hB0, 0);
        settle();
        tick();
        settle();
        check("rm_stb_busy", 32'(s_stb), 1);
        #2 rst = 1'b1;
        #1;
        check("rm_cyc_async", 32'(s_cyc), 0);
        check("rm_stb_async", 32'(s_stb), 0);
        model_reset();
        @(negedge clk);
        settle();
        tick();
        rst = 1'b0;
        settle();
        tick();
        settle();
        check("rm_first_grant", s_addr, 32'hA0);
        tick();

        // Random traffic, including ack/err together and occasional async resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_cyc[i]) m_cyc[i] = ($urandom % 8) != 0;
                else m_cyc[i] = ($urandom % 3) == 0;
                m_stb[i] = m_cyc[i] && (($urandom % 4) != 0);
                m_we[i]  = 1'($urandom);
                m_sel[i*4 +: 4]     = 4'($urandom);
                m_addr[i*32 +: 32]  = $urandom;
                m_wdata[i*32 +: 32] = $urandom;
            end
            s_ack   = ($urandom % 4) == 0;
            s_err   = ($urandom % 16) == 0;
            s_rdata = $urandom;
            rst     = ($urandom % 500) == 0;
            settle();
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin N:1 Wishbone arbiter that merges several bus masters (e.g. instruction fetch and load/store ports) onto the single master port feeding the SoC's combinational 1:N interconnect. Grant is held for the whole `cyc` tenure of the winning master. A per-transfer watchdog terminates stalled transfers with a bus error, so the granted master can never hang the bus.

## Interface

Parameters:
- `N`, default 2: number of upstream masters, 2..8.
- `TimeoutCycles`, default 255: stall limit in cycles.
  - Counter width is `$clog2(TimeoutCycles+1)`.
  - 0 disables the watchdog.

Ports:
- `clk_i`, input, 1: system clock. All state changes on the rising edge.
- `rst_i`, input, 1: asynchronous, active-high reset.
- `bus_in[N-1:0]`, `wb_bus.slave`, –: upstream masters.
  - Inputs: `addr[31:0]`, `wdata[31:0]`, `sel[3:0]`, `we`, `cyc`, `stb`.
  - Outputs: `rdata[31:0]`, `ack`, `err`.
- `bus_out`, `wb_bus.master`, –: single downstream port to the interconnect.

## Operation

- State: `state` ∈ {IDLE, BUSY}; `grant` (index); `last_grant` (index); `wd_cnt` (watchdog counter).
- Request: `req[i] = bus_in[i].cyc & bus_in[i].stb`.
- IDLE:
  - `bus_out` drives all zeros.
  - Every `bus_in[i]` sees `ack=0`, `err=0`, `rdata=0`.
  - If any `req[i]` is set, the winner is the first requesting index scanning `last_grant+1, last_grant+2, …` modulo N.
  - Register the winner into `grant` and `last_grant`; go to BUSY.
- BUSY:
  - `bus_out.{addr,wdata,sel,we,cyc,stb}` = `bus_in[grant]` fields, passed combinationally.
  - `bus_in[grant].{rdata,ack,err}` = `bus_out` fields.
  - All non-granted masters see zeros and remain stalled.
- Release: `bus_in[grant].cyc == 0` in BUSY → IDLE next cycle.
  - `stb` low with `cyc` high keeps the grant, for multi-transfer locked cycles.
- Watchdog, active only when `TimeoutCycles > 0`:
  - In BUSY with `bus_in[grant].stb=1` and `bus_out.ack=0` and `bus_out.err=0`: `wd_cnt` increments.
  - Otherwise `wd_cnt` clears to 0.
  - Timeout condition: `wd_cnt == TimeoutCycles-1` while still stalled. For that one cycle:
    - `bus_in[grant].err` = 1 and `bus_in[grant].ack` = 0.
    - `bus_out.cyc` and `bus_out.stb` are forced to 0, aborting the downstream transfer.
    - `wd_cnt` clears.
  - The grant is retained. The master decides whether to drop `cyc`.
- Downstream `ack` and `err` asserted together: both are passed unmodified. The interconnect never does this; no arbitration of the two is required.
- Non-granted masters may change or drop requests freely; this has no effect until the next IDLE arbitration.

## Timing

- Reset values (asynchronous assertion, `rst_i` high):
  - `state` = IDLE, `grant` = 0, `last_grant` = N-1 (master 0 wins first), `wd_cnt` = 0.
  - All outputs 0.
- Reset mid-transfer: outputs go to 0 immediately and asynchronously. The pending transfer is abandoned with no ack or err.
- Arbitration latency: request sampled in IDLE at edge t → forwarded downstream from cycle t+1.
- Data path: `bus_in[grant]` ↔ `bus_out` is purely combinational in BUSY, with zero added latency.
  - An ack from a zero-wait slave returns in the same cycle `stb` is seen downstream.
- Release and re-arbitration:
  - Grant-holder drops `cyc` in cycle t → IDLE in cycle t+1.
  - A pending request is granted at the t+1 edge and forwarded from t+2.
  - This gives a minimum one-cycle bus turnaround between tenures.
- Simultaneous requests: resolved by the round-robin pointer only. A master requesting in consecutive tenures yields to any other requester.
- Watchdog: `err` appears in the TimeoutCycles-th consecutive stalled cycle, counted from the first cycle `stb` is forwarded.
  - An ack arriving in that same cycle takes priority: it is passed through, no timeout err is raised, and `wd_cnt` clears.

## Test plan

- Reset/idle: hold `rst_i` 3 cycles, then release with no requests → all `bus_in[*]` and `bus_out` signals 0; `state` IDLE.
- Single master: master 1 requests a read of `addr=0x0000_1000`; slave acks with `rdata=0xDEAD_BEEF` one cycle after seeing `stb`.
  - Required: `bus_out.addr=0x1000` from cycle t+1.
  - Required: master 1 sees `ack=1`, `rdata=0xDEADBEEF` at t+2; master 0 sees 0.
- Contention and fairness: masters 0 and 1 both request continuously after reset, each tenure 1 transfer, zero-wait slave.
  - Required grant order: 0,1,0,1 (four tenures).
  - Required: exactly one idle cycle between tenures.
- Locked cycle: master 0 holds `cyc` across two writes (`wdata=0x11`, then `0x22`) with `stb` low for 2 cycles between them, while master 1 requests.
  - Required: master 1 is not granted until master 0 drops `cyc`.
- Timeout: `TimeoutCycles=4`, slave never acks.
  - Required: master sees `err=1` for exactly one cycle, in the 4th stalled cycle.
  - Required: `bus_out.cyc`/`stb` are 0 in that cycle.
  - Variant: ack arriving in the 4th cycle → ack returned, no err.
- Reset mid-transfer: assert `rst_i` while BUSY with `stb` high.
  - Required: `bus_out.cyc`/`stb` fall to 0 in the same cycle, before the next clock edge.
  - Required: the first arbitration after reset grants master 0.
